// File: rtl/fpu_ctrl_pkg.sv
// Shared control definitions for the FP pipeline sequencers.
// Holds the sequencer state encoding and the default stage count per FP unit.
package fpu_ctrl_pkg;

  // Sequencer states; DRAIN is reserved and currently unreachable.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  // Default pipeline depths per FP unit.
  localparam int unsigned MULT_NUM_STAGES = 6;
  localparam int unsigned ADD_NUM_STAGES  = 5;

endpackage : fpu_ctrl_pkg

// File: rtl/pipe_token_shift.sv
// Token shift register with a matching occupancy counter.
// Ports:
//   clk, rst      clock and asynchronous active-low reset
//   shift_en      advance tokens this cycle (frozen when low)
//   in_bit        token entering stage 0 on an advancing edge
//   clr           synchronous discard of all tokens (beats shift_en)
//   v             token vector, bit k = op present in stage k
//   cnt           number of tokens held, always popcount(v)
module pipe_token_shift #(
  parameter int unsigned NUM_STAGES = 6,
  parameter int unsigned CNT_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic                  in_bit,
  input  logic                  clr,
  output logic [NUM_STAGES-1:0] v,
  output logic [CNT_W-1:0]      cnt
);

  logic inc_c;
  logic dec_c;

  // The counter moves with the shift so it never diverges from popcount(v).
  assign inc_c = in_bit;
  assign dec_c = v[NUM_STAGES-1];

  // Token vector and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v   <= '0;
      cnt <= '0;
    end else if (clr) begin
      v   <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      v <= {v[NUM_STAGES-2:0], in_bit};
      if (inc_c && !dec_c) begin
        cnt <= cnt + CNT_W'(1);
      end else if (!inc_c && dec_c) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule : pipe_token_shift

// File: rtl/fsm_pipe_sequencer.sv
// Control sequencer for the FP arithmetic pipelines.
// Tracks op tokens through NUM_STAGES stages, drives one enable per stage,
// and runs either one op at a time (sequential) or one new op per cycle
// (pipelined). Supports stall, flush, a retirement pulse and an in-flight count.
// Ports:
//   clk, rst                clock and asynchronous active-low reset
//   init_OPERATION          request to start a new operation
//   mode_pipelined          1 = pipelined, 0 = sequential; sampled in IDLE
//   stall                   freeze all stages this cycle
//   flush                   discard all in-flight ops
//   enable_Pipeline_input   operand-load strobe (= accept, combinational)
//   stage_en                per-stage register enables (combinational)
//   ready                   sequencer can accept this cycle (combinational)
//   busy                    any op in flight (combinational)
//   done                    registered one-cycle pulse on retirement
//   inflight_cnt            registered count of ops in flight
module fsm_pipe_sequencer
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = MULT_NUM_STAGES,
  parameter int unsigned CNT_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_OPERATION,
  input  logic                  mode_pipelined,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  enable_Pipeline_input,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      inflight_cnt
);

  seq_state_e            state_q;
  seq_state_e            state_d;
  logic                  mode_q;
  logic                  mode_d;
  logic                  ready_c;
  logic                  accept_c;
  logic                  shift_en_c;
  logic [NUM_STAGES-1:0] v;

  // Stages advance only on edges free of stall and flush.
  assign shift_en_c = ~stall & ~flush;

  pipe_token_shift #(
    .NUM_STAGES (NUM_STAGES),
    .CNT_W      (CNT_W)
  ) u_tokens (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en_c),
    .in_bit   (accept_c),
    .clr      (flush),
    .v        (v),
    .cnt      (inflight_cnt)
  );

  // State and latched mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state, ready and accept decode.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    ready_c  = 1'b0;
    accept_c = 1'b0;

    unique case (state_q)
      IDLE:    ready_c = 1'b1;
      RUN:     ready_c = mode_q;
      default: ready_c = 1'b0;
    endcase
    // Reset is folded in so every output reads low while rst is asserted.
    ready_c  = ready_c & shift_en_c & rst;
    accept_c = init_OPERATION & ready_c;

    unique case (state_q)
      IDLE: begin
        mode_d = mode_pipelined;
        if (accept_c) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Leave once the last token retires with nothing new behind it.
        if (flush) begin
          state_d = IDLE;
        end else if (shift_en_c && (v[NUM_STAGES-2:0] == '0) && !accept_c) begin
          state_d = IDLE;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Retirement pulse: the last stage holds a token on an advancing edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= v[NUM_STAGES-1] & shift_en_c;
    end
  end

  assign enable_Pipeline_input = accept_c;
  assign ready                 = ready_c;
  assign stage_en              = v & {NUM_STAGES{shift_en_c}};
  assign busy                  = |v;

endmodule : fsm_pipe_sequencer

// File: doc/fsm_pipe_sequencer.md
Name: fsm_pipe_sequencer

Overview:
Parametrised control sequencer for the FP arithmetic pipelines: the successor to the fixed single-shot multiplier control FSM. It tracks operation tokens through NUM_STAGES stages, drives one enable per stage and supports a sequential mode (one op in flight) and a pipelined mode (one new op per cycle). It adds stall, flush, a completion pulse and an in-flight count. It sits between the operation issuer and the stage registers of the FP datapath.

Parameters:
NUM_STAGES, 6, number of pipeline stages driven (legal range ≥2)
CNT_W, $clog2(NUM_STAGES+1), width of the in-flight counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
init_OPERATION  in  1  request to start a new operation
mode_pipelined  in  1  1 = pipelined mode, 0 = sequential; sampled only in IDLE
stall  in  1  freeze all stages this cycle
flush  in  1  synchronous discard of all in-flight ops
enable_Pipeline_input  out  1  operand-load strobe; equals accept
stage_en  out  NUM_STAGES  per-stage register enable
ready  out  1  sequencer can accept this cycle
busy  out  1  any op in flight
done  out  1  one-cycle pulse when an op leaves the last stage
inflight_cnt  out  CNT_W  number of ops currently in flight

Behaviour:
- Reset (rst=0, async): token vector v=0, state=IDLE, mode_q=0, done=0, inflight_cnt=0. All outputs are low. This holds for reset mid-operation too: all tokens are lost and nothing is reported.
- accept = init_OPERATION & ready & ~stall & ~flush. enable_Pipeline_input = accept (combinational).
- ready:
  - IDLE: 1.
  - RUN with mode_q=1: 1.
  - RUN with mode_q=0: 0.
  - DRAIN: 0.
  - ready is also forced to 0 while stall or flush is high.
- stage_en[k] = v[k] & ~stall & ~flush (combinational from registered v).
- Token shift on a non-stalled, non-flushed edge: v <= {v[NUM_STAGES-2:0], accept}. On a stall edge, v holds.
- done (registered): set on the edge where v[NUM_STAGES-1]=1, stall=0 and flush=0; otherwise 0.
- Latency, no stall: accept in cycle t gives stage_en[k] high in cycle t+1+k and done high in cycle t+NUM_STAGES+1. Each stall cycle adds exactly one cycle.
- inflight_cnt: increments on accept, decrements when the last stage retires. It is unchanged if both happen in the same cycle. It is cleared to 0 by flush. It always equals popcount(v) and never wraps; maximum value is NUM_STAGES.
- busy = (v != 0).
- FSM states:
  - IDLE: mode_q <= mode_pipelined. On accept, go to RUN.
  - RUN: on flush, go to IDLE. When v would become 0 with no accept, go to IDLE. With mode_q=0, the single op advances to retirement and then the FSM returns to IDLE.
  - DRAIN: entered from RUN when init_OPERATION is low and mode_q=1 with ops in flight, only when an explicit drain is wanted. Not entered in this version; the state is encoded but unreachable. Its default branch goes to IDLE.
  - Any illegal state encoding goes to IDLE.
- Simultaneous events:
  - flush beats stall and beats init_OPERATION: no accept, v=0 and IDLE next cycle, no done.
  - stall with init_OPERATION: no accept; the requester must hold init_OPERATION.
  - In pipelined mode, accept and retirement may occur in the same cycle.
- A change of mode_pipelined outside IDLE is ignored until the next IDLE cycle.

Decomposition:
- Shared package fpu_ctrl_pkg holds:
  - the state encoding typedef (IDLE, RUN, DRAIN) on a 2-bit width;
  - a localparam for the default NUM_STAGES per FP unit (MULT=6, ADD=5).
- One natural sub-module, pipe_token_shift: token vector register plus popcount counter, with parameter NUM_STAGES and inputs shift_en, in_bit and clr. The FSM lives in the top level.

Test Plan:
- Sequential mode, NUM_STAGES=6: init_OPERATION held high from cycle 1 → accept in cycle 1; stage_en one-hot walks bits 0..5 in cycles 2..7; done in cycle 8; next accept in cycle 8 (ready=1 only after retire). No overlap occurs.
- Pipelined mode: init_OPERATION held for 10 cycles → 10 accepts. inflight_cnt saturates at 6. done pulses in 10 consecutive cycles starting 7 cycles after the first accept. inflight_cnt returns to 0 and the FSM returns to IDLE.
- Stall: one op accepted, then stall=1 for 3 cycles while v[2]=1 → stage_en=0 during the stall and v holds; done is delayed by exactly 3 cycles (cycle t+10).
- Flush with init_OPERATION and stall all high, 4 ops in flight → no accept that cycle; next cycle v=0, inflight_cnt=0, IDLE, ready=1; no done pulse.
- Async reset asserted mid-flight (rst=0 between clock edges) → all outputs 0 immediately. After release, the first accept shows full latency (done at t+7).
- Mode change: mode_pipelined toggled 1→0 while in RUN → behaviour stays pipelined until IDLE. The next op after IDLE runs sequential (ready=0 while busy).
